muldiv_iter: RTL and testbench

Parametrised iterative RV32M multiply/divide unit for the EX stage, replacing the fixed 32-bit muldiv.
- Supports all eight M-extension ops selected by funct3.
- Multiply and divide retire a configurable number of bits per cycle.
- Adds a flush input, a hold input, a busy/resp handshake and single-cycle special-case divides.
- EX raises its pipeline stall on (start & !resp).

---
 rtl/muldiv_iter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit for the EX stage.
// It supports all eight M-extension ops, selected by funct3.
// The multiplier is shift-and-add and retires MUL_STEP bits per cycle.
// The divider is restoring and produces DIV_STEP quotient bits per cycle.
// Both work on operand magnitudes; the sign is fixed when the result is
// registered into f on entry to DONE.
// Divide by zero and signed overflow finish in one cycle.
// Optional feature macro: MULDIV_FUSE_EN. When defined, the last divide's
// quotient and remainder are cached, so a DIV/REM (or DIVU/REMU) pair on the
// same operands completes in one cycle.
// Handshake: start is sampled only in IDLE. resp is high for every cycle in
// DONE and f is valid while resp is high. busy is high while iterating.
// resp and busy are never high together. flush returns the unit to IDLE.
// flush has priority over start and hold. Parameter legality (WIDTH even
// and >= 8, steps dividing WIDTH) is the instantiator's responsibility.
module muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hold,
    output logic             busy,
    output logic             resp,
    output logic [WIDTH-1:0] f
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH / MUL_STEP);
    localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH / DIV_STEP);
    localparam logic [W-1:0]  SMIN    = {1'b1, {(W-1){1'b0}}};

    // state_q is the FSM state that checkers observe.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;        // negate product / quotient
    logic            rneg_q, rneg_d;      // negate remainder (sign of a)
    logic [2*W-1:0]  mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [W-1:0]    mplier_q, mplier_d;  // multiplier, shifted right each step
    logic [2*W-1:0]  acc_q, acc_d;        // product, or {remainder, dividend/quotient}
    logic [W-1:0]    dvs_q, dvs_d;        // divisor magnitude
    logic [W-1:0]    f_q, f_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic            div_ovf;
    logic [2*W-1:0]  mul_acc, mul_mc;
    logic [W-1:0]    mul_mp;
    logic [2*W-1:0]  div_acc;
    logic [W:0]      div_r;
    logic            div_qbit;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix, mul_res, div_res;

`ifdef MULDIV_FUSE_EN
    logic            cache_vld_q, cache_vld_d;
    logic            cache_sgn_q, cache_sgn_d;
    logic [W-1:0]    cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic [W-1:0]    cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
    logic            cache_hit;

    assign cache_hit = cache_vld_q && funct3[2] && (a == cache_a_q) &&
                       (b == cache_b_q) && (!funct3[0] == cache_sgn_q);
`endif

    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign resp = (state_q == S_DONE);
    assign f    = f_q;

    // Operand signedness per funct3, and magnitudes of the incoming operands.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'd2:                   a_signed = 1'b1;
            default:                ;
        endcase
        a_neg   = a_signed & a[W-1];
        b_neg   = b_signed & b[W-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        div_ovf = !funct3[0] && (a == SMIN) && (b == '1);
    end

    // One multiply iteration: add MUL_STEP shifted partial products.
    always_comb begin
        mul_acc = acc_q;
        mul_mc  = mcand_q;
        mul_mp  = mplier_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mul_mp[0]) mul_acc = mul_acc + mul_mc;
            mul_mc = mul_mc << 1;
            mul_mp = mul_mp >> 1;
        end
    end

    // One divide iteration: DIV_STEP restoring shift/subtract steps.
    always_comb begin
        div_acc  = acc_q;
        div_r    = '0;
        div_qbit = 1'b0;
        for (int i = 0; i < DIV_STEP; i++) begin
            div_r    = {div_acc[2*W-1:W], div_acc[W-1]};
            div_qbit = (div_r >= {1'b0, dvs_q});
            if (div_qbit) div_r = div_r - {1'b0, dvs_q};
            div_acc  = {div_r[W-1:0], div_acc[W-2:0], div_qbit};
        end
    end

    // Sign fix and result select, applied to the final iteration's value.
    always_comb begin
        prod_fix = neg_q  ? -mul_acc : mul_acc;
        quo_fix  = neg_q  ? -div_acc[W-1:0] : div_acc[W-1:0];
        rem_fix  = rneg_q ? -div_acc[2*W-1:W] : div_acc[2*W-1:W];
        mul_res  = (op_q[1:0] == 2'd0) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        div_res  = op_q[1] ? rem_fix : quo_fix;
    end

    // FSM next state and datapath updates; flush overrides everything last.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        f_d      = f_q;
`ifdef MULDIV_FUSE_EN
        cache_vld_d = cache_vld_q;
        cache_sgn_d = cache_sgn_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_quo_d = cache_quo_q;
        cache_rem_d = cache_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d   = funct3;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (!funct3[2]) begin
                        state_d  = S_MUL;
                        cnt_d    = MUL_CNT;
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, a_mag};
                        mplier_d = b_mag;
`ifdef MULDIV_FUSE_EN
                    end else if (cache_hit) begin
                        state_d = S_DONE;
                        f_d     = funct3[1] ? cache_rem_q : cache_quo_q;
`endif
                    end else if (b == '0) begin
                        state_d = S_DONE;
                        f_d     = funct3[1] ? a : '1;
                    end else if (div_ovf) begin
                        state_d = S_DONE;
                        f_d     = funct3[1] ? '0 : SMIN;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = DIV_CNT;
                        acc_d   = {{W{1'b0}}, a_mag};
                        dvs_d   = b_mag;
`ifdef MULDIV_FUSE_EN
                        cache_vld_d = 1'b0;
                        cache_a_d   = a;
                        cache_b_d   = b;
                        cache_sgn_d = !funct3[0];
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_acc;
                mcand_d  = mul_mc;
                mplier_d = mul_mp;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    f_d     = mul_res;
                end
            end
            S_DIV: begin
                acc_d = div_acc;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    f_d     = div_res;
`ifdef MULDIV_FUSE_EN
                    cache_vld_d = 1'b1;
                    cache_quo_d = quo_fix;
                    cache_rem_d = rem_fix;
`endif
                end
            end
            S_DONE: begin
                if (!hold) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            f_d     = f_q;
`ifdef MULDIV_FUSE_EN
            cache_vld_d = 1'b0;
`endif
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            f_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            f_q      <= f_d;
        end
    end

`ifdef MULDIV_FUSE_EN
    // Divide result cache registers, invalidated by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_vld_q <= 1'b0;
            cache_sgn_q <= 1'b0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_quo_q <= '0;
            cache_rem_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_sgn_q <= cache_sgn_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_quo_q <= cache_quo_d;
            cache_rem_q <= cache_rem_d;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter at default parameters (32-bit, 2 mul bits/cycle,
// 1 div bit/cycle). Expected results come from a plain-arithmetic model.
module tb_muldiv_iter;
  localparam int W        = 32;
  localparam int MUL_STEP = 2;
  localparam int DIV_STEP = 1;
  localparam logic [W-1:0] SMIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         hold = 1'b0;
  logic         busy;
  logic         resp;
  logic [W-1:0] f;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_f = '0;
  logic         resp_prev = 1'b0;
  // model of the divide cache (used only when the feature is built in)
  bit           mvld = 1'b0;
  bit           mkey_s = 1'b0;
  logic [W-1:0] mkey_a = '0;
  logic [W-1:0] mkey_b = '0;

  muldiv_iter dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .hold(hold), .busy(busy), .resp(resp), .f(f)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // reference model: plain 64-bit arithmetic on the RV32M definitions
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p;
    longint unsigned ux, uy, up;
    logic [W-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r = '0;
    case (op)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
      3'd3: begin up = ux * uy; r = up[63:32]; end
      3'd4: begin
        if (y == 0) r = '1;
        else if (x == SMIN && y == '1) r = SMIN;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: begin
        if (y == 0) r = '1;
        else begin up = ux / uy; r = up[31:0]; end
      end
      3'd6: begin
        if (y == 0) r = x;
        else if (x == SMIN && y == '1) r = '0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else begin up = ux % uy; r = up[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit fuse_hit(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bit h;
    h = 1'b0;
`ifdef MULDIV_FUSE_EN
    h = mvld && op[2] && x == mkey_a && y == mkey_b && (!op[0]) == mkey_s;
`endif
    return h;
  endfunction

  // expected number of cycles from accept to the first resp cycle
  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (op < 4) return W / MUL_STEP + 1;
    if (fuse_hit(op, x, y)) return 1;
    if (y == 0) return 1;
    if (!op[0] && x == SMIN && y == '1) return 1;
    return W / DIV_STEP + 1;
  endfunction

  // driver: issue one op, check latency/busy, optionally hold in DONE
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int h);
    int lat, cyc, busy_bad;
    bit normal_div;
    lat = ref_lat(op, x, y);
    normal_div = op[2] && lat > 1;
    @(negedge clk);
    start = 1'b1; funct3 = op; a = x; b = y;
    exp_q.push_back(ref_model(op, x, y));
    if (normal_div) mvld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
    cyc = 1;
    busy_bad = 0;
    while (!resp && cyc < 200) begin
      if (!busy) busy_bad++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("latency", W'(cyc), W'(lat));
    check("busy_while_iterating", W'(busy_bad), '0);
    if (resp) begin
      last_f = ref_model(op, x, y);
      if (normal_div) begin
        mvld = 1'b1; mkey_a = x; mkey_b = y; mkey_s = !op[0];
      end
    end
    if (h > 0) begin
      hold = 1'b1;
      repeat (h) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_resp", W'(resp), W'(1));
        check("hold_f", f, last_f);
      end
      hold = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("idle_after_done_resp", W'(resp), '0);
    check("idle_after_done_busy", W'(busy), '0);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    mvld = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return SMIN;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // scoreboard monitor: compare on every rising resp, check exclusivity
  always @(negedge clk) begin
    if (rst) begin
      check("busy_resp_exclusive", W'(busy && resp), '0);
      if (resp && !resp_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp actual=%h required=no_resp", f);
        end else begin
          check("result", f, exp_q.pop_front());
        end
      end
      resp_prev <= resp;
    end else begin
      resp_prev <= 1'b0;
    end
  end

  initial begin
    logic [2:0] op;
    logic [W-1:0] x, y;
    int cyc;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_resp", W'(resp), '0);
    check("reset_f", f, '0);
    rst = 1'b1;

    // directed multiplies and divides
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(3'd1, SMIN, SMIN, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 5);

    // special-case divides
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 0);
    do_op(3'd4, SMIN, 32'hFFFF_FFFF, 0);
    do_op(3'd6, SMIN, 32'hFFFF_FFFF, 2);

    // flush at cycle 10 of a divide: no resp, f unchanged
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; a = 32'd1000; b = 32'd3;
    mvld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    check("flush_resp", W'(resp), '0);
    check("flush_f", f, last_f);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush_no_resp", W'(resp), '0);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd12345; b = 32'd17;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_busy", W'(busy), '0);
    check("midreset_resp", W'(resp), '0);
    check("midreset_f", f, '0);
    rst = 1'b1;
    last_f = '0;
    mvld = 1'b0;
    do_op(3'd0, 32'd3, 32'd4, 0);

`ifdef MULDIV_FUSE_EN
    do_op(3'd4, 32'd100, 32'd7, 0);
    do_op(3'd6, 32'd100, 32'd7, 0);
    flush_idle();
    do_op(3'd6, 32'd100, 32'd7, 0);
`endif

    // randomized ops, sometimes reusing the previous operands
    x = '0;
    y = '0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        x = pick_operand();
        y = pick_operand();
      end
      if ($urandom_range(0, 9) == 0) flush_idle();
      do_op(op, x, y, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
